// File: rtl/snitch_regfile_wb_pkg.sv
// Shared types for the register-file write-back arbiter: request struct, word count, one-hot decode.
package snitch_regfile_wb_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NumWords   = 2**ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [NumWords-1:0] onehot_addr(input logic [ADDR_WIDTH-1:0] addr);
    logic [NumWords-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/snitch_wb_rr_arb.sv
// Write-back grant selection: one-hot grant plus index, combinational, no back-pressure.
// SNITCH_WB_ARB_RR_EN selects round-robin (pointer advances past each winner); otherwise lowest index wins.
module snitch_wb_rr_arb #(
  parameter int unsigned NR_SOURCES = 3,
  parameter int unsigned IDX_WIDTH  = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1
) (
`ifdef SNITCH_WB_ARB_RR_EN
  input  logic                  clk_i,
  input  logic                  rst_ni,
`endif
  input  logic [NR_SOURCES-1:0] valid_i,
  output logic [NR_SOURCES-1:0] gnt_o,
  output logic [IDX_WIDTH-1:0]  idx_o
);

  if (NR_SOURCES == 1) begin : gen_single
    assign gnt_o = valid_i;
    assign idx_o = '0;
  end else begin : gen_multi
`ifdef SNITCH_WB_ARB_RR_EN
    logic [IDX_WIDTH-1:0] ptr_q;

    // Scan starting at the pointer, wrapping once around the sources.
    always_comb begin
      int unsigned j;
      logic        found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < NR_SOURCES; i++) begin
        j = 32'(ptr_q) + i;
        if (j >= NR_SOURCES) j = j - NR_SOURCES;
        if (!found && valid_i[IDX_WIDTH'(j)]) begin
          gnt_o[IDX_WIDTH'(j)] = 1'b1;
          idx_o                = IDX_WIDTH'(j);
          found                = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ptr_q <= '0;
      end else if (|valid_i) begin
        ptr_q <= (idx_o == IDX_WIDTH'(NR_SOURCES - 1)) ? '0 : idx_o + 1'b1;
      end
    end
`else
    always_comb begin
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NR_SOURCES; i++) begin
        if (!found && valid_i[IDX_WIDTH'(i)]) begin
          gnt_o[IDX_WIDTH'(i)] = 1'b1;
          idx_o                = IDX_WIDTH'(i);
          found                = 1'b1;
        end
      end
    end
`endif
  end

endmodule

// File: rtl/snitch_regfile_wb_arbiter.sv
// Register-file write front end: arbitrated write port registered (handshake N -> we_o N+1), busy scoreboard.
// Producers are never back-pressured beyond losing arbitration; SNITCH_WB_ARB_RR_EN enables round-robin.
module snitch_regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = snitch_regfile_wb_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = snitch_regfile_wb_pkg::ADDR_WIDTH,
  parameter int unsigned NR_SOURCES    = 3,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NR_SOURCES-1:0]                 src_valid_i,
  output logic [NR_SOURCES-1:0]                 src_ready_o,
  input  logic [NR_SOURCES-1:0][ADDR_WIDTH-1:0] src_addr_i,
  input  logic [NR_SOURCES-1:0][DATA_WIDTH-1:0] src_data_i,
  input  logic                                  rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 rsv_addr_i,
  output logic [2**ADDR_WIDTH-1:0]              busy_o,
  output logic                                  we_o,
  output logic [ADDR_WIDTH-1:0]                 waddr_o,
  output logic [DATA_WIDTH-1:0]                 wdata_o
);

  import snitch_regfile_wb_pkg::*;

  localparam int unsigned IdxWidth = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;

  logic [NR_SOURCES-1:0] gnt;
  logic [IdxWidth-1:0]   gnt_idx;
  logic                  hs;
  logic                  wr_en;
  wb_req_t               req;
  wb_req_t               out_q;
  logic                  we_q;
  logic [NumWords-1:0]   busy_q;
  logic [NumWords-1:0]   busy_d;

  snitch_wb_rr_arb #(
    .NR_SOURCES(NR_SOURCES),
    .IDX_WIDTH (IdxWidth)
  ) i_arb (
`ifdef SNITCH_WB_ARB_RR_EN
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
`endif
    .valid_i(src_valid_i),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign src_ready_o = gnt;
  assign hs          = |gnt;
  assign req.addr    = src_addr_i[gnt_idx];
  assign req.data    = src_data_i[gnt_idx];
  // Writes to the hardwired zero register are consumed but never reach the port.
  assign wr_en       = hs && !(ZERO_REG_ZERO && (req.addr == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q <= wr_en;
      if (wr_en) out_q <= req;
    end
  end

  // Reservation applied after the commit clear so a same-cycle re-reservation keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (we_q)        busy_d &= ~onehot_addr(out_q.addr);
    if (rsv_valid_i) busy_d |= onehot_addr(rsv_addr_i);
    if (ZERO_REG_ZERO) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o  = busy_q;
  assign we_o    = we_q;
  assign waddr_o = out_q.addr;
  assign wdata_o = out_q.data;

  for (genvar i = 0; i < NR_SOURCES; i++) begin : gen_hold_checks
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (src_valid_i[i] && !src_ready_o[i]) |=>
        (src_valid_i[i] && $stable(src_addr_i[i]) && $stable(src_data_i[i])));
  end

endmodule

// File: tb/tb_snitch_regfile_wb_arbiter.sv
// Directed bench for snitch_regfile_wb_arbiter; expectations follow SNITCH_WB_ARB_RR_EN when defined.
module tb_snitch_regfile_wb_arbiter;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NS-1:0]         src_valid;
  logic [NS-1:0]         src_ready;
  logic [NS-1:0][AW-1:0] src_addr;
  logic [NS-1:0][DW-1:0] src_data;
  logic                  rsv_valid;
  logic [AW-1:0]         rsv_addr;
  logic [2**AW-1:0]      busy;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DW-1:0]         wdata;

  int checks   = 0;
  int failures = 0;

  snitch_regfile_wb_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .src_addr_i (src_addr),
    .src_data_i (src_data),
    .rsv_valid_i(rsv_valid),
    .rsv_addr_i (rsv_addr),
    .busy_o     (busy),
    .we_o       (we),
    .waddr_o    (waddr),
    .wdata_o    (wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    src_valid = '0;
    rsv_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    checks++; if (wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    src_valid   = 3'b010;
    src_addr[1] = 5'd5;
    src_data[1] = 32'hDEADBEEF;
    #1;
    checks++; if (src_ready !== 3'b010) begin failures++; $display("FAIL single_ready got=%b exp=010", src_ready); end
    tick();
    src_valid = '0;
    checks++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got we=%b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", we, waddr, wdata);
    end
    tick();
    checks++; if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_idle got we=%b addr=%0d data=%h exp we=0 addr=5 data=deadbeef", we, waddr, wdata);
    end
  endtask

  task automatic test_arbitration();
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] r;
    int            exp_src;
    int            guard;
    apply_reset();
    for (int s = 0; s < NS; s++) begin
      src_addr[s] = AW'(s + 1);
      src_data[s] = 32'hA0 + DW'(s);
    end
    src_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
`ifdef SNITCH_WB_ARB_RR_EN
      exp_src = k % 3;
`else
      exp_src = 0;
`endif
      exp_rdy = 3'b001 << exp_src;
      #1;
      checks++; if (src_ready !== exp_rdy) begin failures++; $display("FAIL arb_ready k=%0d got=%b exp=%b", k, src_ready, exp_rdy); end
      tick();
      checks++; if (we !== 1'b1 || waddr !== AW'(exp_src + 1) || wdata !== 32'hA0 + DW'(exp_src)) begin
        failures++; $display("FAIL arb_write k=%0d got we=%b addr=%0d data=%h exp src %0d", k, we, waddr, wdata, exp_src);
      end
    end
    guard = 0;
    while (src_valid != '0 && guard < 20) begin
      #1;
      r = src_ready;
      tick();
      src_valid = src_valid & ~r;
      guard++;
    end
    checks++; if (src_valid !== '0) begin failures++; $display("FAIL arb_drain got valid=%b exp=000", src_valid); end
    tick();
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL sb_set got=%h exp=00000080", busy); end
    tick();
    tick();
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL sb_hold got=%h exp=00000080", busy); end
    src_valid   = 3'b100;
    src_addr[2] = 5'd7;
    src_data[2] = 32'h7777_0007;
    #1;
    checks++; if (src_ready !== 3'b100) begin failures++; $display("FAIL sb_ready got=%b exp=100", src_ready); end
    tick();
    src_valid = '0;
    checks++; if (we !== 1'b1 || waddr !== 5'd7 || busy !== 32'h0000_0080) begin
      failures++; $display("FAIL sb_commit got we=%b addr=%0d busy=%h exp we=1 addr=7 busy=00000080", we, waddr, busy);
    end
    tick();
    checks++; if (busy !== '0 || we !== 1'b0) begin failures++; $display("FAIL sb_clear got busy=%h we=%b exp busy=0 we=0", busy, we); end
  endtask

  task automatic test_set_wins();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL sw_set got=%h exp=00000200", busy); end
    src_valid   = 3'b001;
    src_addr[0] = 5'd9;
    src_data[0] = 32'h0000_9999;
    tick();
    src_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    checks++; if (we !== 1'b1 || waddr !== 5'd9) begin failures++; $display("FAIL sw_commit got we=%b addr=%0d exp we=1 addr=9", we, waddr); end
    tick();
    rsv_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL sw_set_wins got=%h exp=00000200", busy); end
    src_valid   = 3'b001;
    src_data[0] = 32'h0000_009A;
    tick();
    src_valid = '0;
    checks++; if (we !== 1'b1 || wdata !== 32'h0000_009A || busy !== 32'h0000_0200) begin
      failures++; $display("FAIL sw_second got we=%b data=%h busy=%h exp we=1 data=9a busy=00000200", we, wdata, busy);
    end
    tick();
    checks++; if (busy !== '0) begin failures++; $display("FAIL sw_clear got=%h exp=0", busy); end
  endtask

  task automatic test_zero_reg();
    src_valid   = 3'b010;
    src_addr[1] = 5'd0;
    src_data[1] = 32'h0000_1234;
    rsv_valid   = 1'b1;
    rsv_addr    = 5'd0;
    #1;
    checks++; if (src_ready !== 3'b010) begin failures++; $display("FAIL zero_ready got=%b exp=010", src_ready); end
    tick();
    src_valid = '0;
    rsv_valid = 1'b0;
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL zero_we got=%b exp=0", we); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL zero_busy got=%h exp=0", busy); end
    tick();
    checks++; if (we !== 1'b0 || busy !== '0) begin failures++; $display("FAIL zero_after got we=%b busy=%h exp we=0 busy=0", we, busy); end
  endtask

  task automatic test_reset_mid();
    src_valid   = 3'b001;
    src_addr[0] = 5'd12;
    src_data[0] = 32'h00C0_FFEE;
    rsv_valid   = 1'b1;
    rsv_addr    = 5'd12;
    tick();
    src_valid = '0;
    rsv_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || busy !== '0) begin failures++; $display("FAIL rstmid_clear got we=%b busy=%h exp we=0 busy=0", we, busy); end
    checks++; if (waddr !== '0 || wdata !== '0) begin failures++; $display("FAIL rstmid_out got addr=%0d data=%h exp 0", waddr, wdata); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (we !== 1'b0 || busy !== '0) begin failures++; $display("FAIL rstmid_release k=%0d got we=%b busy=%h exp we=0 busy=0", k, we, busy); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_scoreboard();
    test_set_wins();
    test_zero_reg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
